// File: rtl/fence_controller.sv
// Sequencer for FENCE / FENCE.I / SFENCE.VMA: stalls ID, drains the back end,
// requests the I-cache invalidate or TLB flush, then releases ID and redirects fetch.
module fence_controller #(
    parameter int          DRAIN_MIN   = 2,
    parameter int          ACK_TIMEOUT = 1024,
    parameter logic [3:0]  FLUSH_EARLY = 4'b0110,
    parameter logic [3:0]  FLUSH_ALL   = 4'b0111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  hazard_signal,
    input  logic        id_valid,
    input  logic [31:0] id_instruction,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs1_val,
    input  logic        pipe_busy,
    input  logic        sb_empty,
    output logic        icache_inv_req,
    input  logic        icache_inv_ack,
    output logic        tlb_flush_req,
    output logic        tlb_flush_all,
    output logic [31:0] tlb_flush_vaddr,
    input  logic        tlb_flush_ack,
    output logic        fence_stall,
    output logic        fence_done,
    output logic        fence_error,
    output logic        refetch_valid,
    output logic [31:0] refetch_pc
);

    typedef enum logic [2:0] {IDLE, DRAIN, ICINV, TLBFL, DONE} state_t;
    typedef enum logic [1:0] {K_FENCE, K_FENCEI, K_SFENCE} kind_t;

    localparam logic [3:0]  DRAIN_LAST = 4'(DRAIN_MIN - 1);
    localparam logic [15:0] ACK_LAST   = 16'(ACK_TIMEOUT - 1);

    state_t      state;
    kind_t       cap_kind;
    logic [31:0] cap_pc;
    logic [3:0]  drain_cnt;
    logic [15:0] ack_cnt;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_field;
    logic [4:0] rs1_field;
    logic       is_fence, is_fencei, is_sfence;
    logic       fence_detect, flush, ack_in;
    logic       unused_bits;

    assign opcode    = id_instruction[6:0];
    assign rd_field  = id_instruction[11:7];
    assign funct3    = id_instruction[14:12];
    assign rs1_field = id_instruction[19:15];
    assign funct7    = id_instruction[31:25];
    // rs2 (ASID) is not used: every SFENCE.VMA flushes regardless of address space.
    assign unused_bits = ^id_instruction[24:20];

    assign is_fence  = (opcode == 7'b0001111) && (funct3 == 3'b000);
    assign is_fencei = (opcode == 7'b0001111) && (funct3 == 3'b001);
    assign is_sfence = (opcode == 7'b1110011) && (funct3 == 3'b000) &&
                       (funct7 == 7'b0001001) && (rd_field == 5'd0);

    assign fence_detect = id_valid && (is_fence || is_fencei || is_sfence);
    assign flush        = (hazard_signal == FLUSH_EARLY) || (hazard_signal == FLUSH_ALL);
    assign ack_in       = (state == ICINV) ? icache_inv_ack : tlb_flush_ack;

    // Stall is raised in the detect cycle itself so ID holds the fence; released in DONE.
    assign fence_stall = !rst &&
                         (((state == IDLE) && fence_detect && !flush) ||
                          (state == DRAIN) || (state == ICINV) || (state == TLBFL));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cap_kind        <= K_FENCE;
            cap_pc          <= 32'd0;
            drain_cnt       <= 4'd0;
            ack_cnt         <= 16'd0;
            icache_inv_req  <= 1'b0;
            tlb_flush_req   <= 1'b0;
            tlb_flush_all   <= 1'b0;
            tlb_flush_vaddr <= 32'd0;
            fence_done      <= 1'b0;
            fence_error     <= 1'b0;
            refetch_valid   <= 1'b0;
            refetch_pc      <= 32'd0;
        end else begin
            fence_done    <= 1'b0;
            fence_error   <= 1'b0;
            refetch_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (fence_detect && !flush) begin
                        cap_kind        <= is_fence ? K_FENCE : (is_fencei ? K_FENCEI : K_SFENCE);
                        cap_pc          <= id_pc;
                        tlb_flush_vaddr <= id_rs1_val;
                        tlb_flush_all   <= (rs1_field == 5'd0);
                        drain_cnt       <= 4'd0;
                        state           <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if ((drain_cnt >= DRAIN_LAST) && !pipe_busy && sb_empty) begin
                        ack_cnt <= 16'd0;
                        case (cap_kind)
                            K_FENCEI: begin
                                state          <= ICINV;
                                icache_inv_req <= 1'b1;
                            end
                            K_SFENCE: begin
                                state         <= TLBFL;
                                tlb_flush_req <= 1'b1;
                            end
                            default: begin
                                state      <= DONE;
                                fence_done <= 1'b1;
                            end
                        endcase
                    end else if (drain_cnt != 4'hF) begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                // Ack wins over a same-cycle timeout; a flush wins over both.
                ICINV, TLBFL: begin
                    if (flush) begin
                        state          <= IDLE;
                        icache_inv_req <= 1'b0;
                        tlb_flush_req  <= 1'b0;
                    end else if (ack_in || (ack_cnt == ACK_LAST)) begin
                        state          <= DONE;
                        icache_inv_req <= 1'b0;
                        tlb_flush_req  <= 1'b0;
                        fence_done     <= 1'b1;
                        fence_error    <= !ack_in;
                        refetch_valid  <= 1'b1;
                        refetch_pc     <= cap_pc + 32'd4;
                    end else begin
                        ack_cnt <= ack_cnt + 16'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fence_controller.sv
// Scoreboard bench for fence_controller: stimulus queues expected completions,
// a negedge monitor pops and compares them whenever fence_done is seen.
module tb_fence_controller;

    localparam logic [3:0]  FLUSH_EARLY = 4'b0110;
    localparam logic [3:0]  FLUSH_ALL   = 4'b0111;
    localparam logic [31:0] I_FENCE     = 32'h0FF0000F;
    localparam logic [31:0] I_FENCEI    = 32'h0000100F;
    localparam logic [31:0] I_SF_X5     = 32'h12028073;
    localparam logic [31:0] I_SF_X0     = 32'h12000073;
    localparam logic [31:0] I_ADD       = 32'h00B50533;

    logic        clk, rst;
    logic [3:0]  hazard_signal;
    logic        id_valid;
    logic [31:0] id_instruction, id_pc, id_rs1_val;
    logic        pipe_busy, sb_empty;
    logic        icache_inv_req, icache_inv_ack;
    logic        tlb_flush_req, tlb_flush_all, tlb_flush_ack;
    logic [31:0] tlb_flush_vaddr;
    logic        fence_stall, fence_done, fence_error, refetch_valid;
    logic [31:0] refetch_pc;

    typedef struct {
        int          cyc;
        logic        err;
        logic        rv;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   fails   = 0;
    int   cyc     = 0;

    fence_controller #(
        .DRAIN_MIN  (2),
        .ACK_TIMEOUT(8),
        .FLUSH_EARLY(FLUSH_EARLY),
        .FLUSH_ALL  (FLUSH_ALL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .hazard_signal  (hazard_signal),
        .id_valid       (id_valid),
        .id_instruction (id_instruction),
        .id_pc          (id_pc),
        .id_rs1_val     (id_rs1_val),
        .pipe_busy      (pipe_busy),
        .sb_empty       (sb_empty),
        .icache_inv_req (icache_inv_req),
        .icache_inv_ack (icache_inv_ack),
        .tlb_flush_req  (tlb_flush_req),
        .tlb_flush_all  (tlb_flush_all),
        .tlb_flush_vaddr(tlb_flush_vaddr),
        .tlb_flush_ack  (tlb_flush_ack),
        .fence_stall    (fence_stall),
        .fence_done     (fence_done),
        .fence_error    (fence_error),
        .refetch_valid  (refetch_valid),
        .refetch_pc     (refetch_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [31:0] rs1, input logic busy, input logic [3:0] haz);
        id_valid       = v;
        id_instruction = instr;
        id_pc          = pc;
        id_rs1_val     = rs1;
        pipe_busy      = busy;
        sb_empty       = 1'b1;
        hazard_signal  = haz;
        #1;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic expectDone(input int c, input logic err, input logic rv, input logic [31:0] pc);
        exp_t e;
        e.cyc = c; e.err = err; e.rv = rv; e.pc = pc;
        exp_q.push_back(e);
    endtask

    // Completion monitor: every fence_done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && fence_done) begin
            if (exp_q.size() == 0) begin
                vectors++;
                fails++;
                $display("[TB] FAIL unexpected_done: fence_done=1 at cycle %0d, expected none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("done_cycle", cyc, mon_e.cyc);
                checkOutput("done_error", {31'd0, fence_error}, {31'd0, mon_e.err});
                checkOutput("done_refetch_valid", {31'd0, refetch_valid}, {31'd0, mon_e.rv});
                if (mon_e.rv) checkOutput("done_refetch_pc", refetch_pc, mon_e.pc);
            end
        end else if (!rst && (refetch_valid || fence_error)) begin
            vectors++;
            fails++;
            $display("[TB] FAIL stray_pulse: refetch_valid=%b fence_error=%b without fence_done, expected 0",
                     refetch_valid, fence_error);
        end
    end

    // Plain FENCE on an idle pipe: 3 stall cycles, done at detect+3, no requests.
    task automatic runFence(input logic [31:0] pc);
        int c, stalls;
        logic req_seen;
        stalls = 0;
        req_seen = 1'b0;
        step();
        c = cyc;
        expectDone(c + 3, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) step();
            applyStimulus(i == 0, I_FENCE, pc, 32'd0, 1'b0, 4'd0);
            stalls += int'(fence_stall);
            req_seen = req_seen | icache_inv_req | tlb_flush_req;
        end
        checkOutput("fence_stall_cycles", stalls, 3);
        checkOutput("fence_no_req", {31'd0, req_seen}, 32'd0);
    endtask

    initial begin
        int c;
        rst = 1'b1;
        icache_inv_ack = 1'b0;
        tlb_flush_ack  = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0);
        repeat (3) step();
        checkOutput("reset_stall", {31'd0, fence_stall}, 32'd0);
        checkOutput("reset_done", {31'd0, fence_done}, 32'd0);
        checkOutput("reset_reqs", {30'd0, icache_inv_req, tlb_flush_req}, 32'd0);
        checkOutput("reset_refetch_pc", refetch_pc, 32'd0);
        checkOutput("reset_vaddr", tlb_flush_vaddr, 32'd0);
        rst = 1'b0;

        $display("[TB] plain FENCE");
        runFence(32'h0000_0100);

        $display("[TB] FENCE.I with busy pipe and delayed ack");
        step();
        c = cyc;
        expectDone(c + 10, 1'b0, 1'b1, 32'h8000_1000);
        for (int i = 0; i <= 11; i++) begin
            if (i > 0) step();
            applyStimulus(i == 0, I_FENCEI, 32'h8000_0FFC, 32'd0, i < 5, 4'd0);
            icache_inv_ack = (i == 9);
            checkOutput($sformatf("fencei_req_%0d", i), {31'd0, icache_inv_req}, {31'd0, i >= 6 && i <= 9});
            checkOutput($sformatf("fencei_stall_%0d", i), {31'd0, fence_stall}, {31'd0, i <= 9});
        end
        icache_inv_ack = 1'b0;

        $display("[TB] SFENCE.VMA x5");
        step();
        c = cyc;
        expectDone(c + 5, 1'b0, 1'b1, 32'h0000_1004);
        for (int i = 0; i <= 6; i++) begin
            if (i > 0) step();
            applyStimulus(i == 0, I_SF_X5, 32'h0000_1000, (i == 0) ? 32'h4000_1234 : 32'hDEAD_BEEF, 1'b0, 4'd0);
            tlb_flush_ack = (i == 4);
            checkOutput($sformatf("sfx5_req_%0d", i), {31'd0, tlb_flush_req}, {31'd0, i >= 3 && i <= 4});
            if (i >= 3 && i <= 4) begin
                checkOutput("sfx5_flush_all", {31'd0, tlb_flush_all}, 32'd0);
                checkOutput("sfx5_vaddr", tlb_flush_vaddr, 32'h4000_1234);
            end
        end
        tlb_flush_ack = 1'b0;

        $display("[TB] SFENCE.VMA x0 with stuck-high ack");
        step();
        c = cyc;
        expectDone(c + 4, 1'b0, 1'b1, 32'h0000_2004);
        for (int i = 0; i <= 5; i++) begin
            if (i > 0) step();
            applyStimulus(i == 0, I_SF_X0, 32'h0000_2000, 32'h1111_2222, 1'b0, 4'd0);
            tlb_flush_ack = (i <= 4);
            checkOutput($sformatf("sfx0_req_%0d", i), {31'd0, tlb_flush_req}, {31'd0, i == 3});
            if (i == 3) checkOutput("sfx0_flush_all", {31'd0, tlb_flush_all}, 32'd1);
        end
        tlb_flush_ack = 1'b0;

        $display("[TB] FENCE.I ack timeout with PC wrap and late ack");
        step();
        c = cyc;
        expectDone(c + 11, 1'b1, 1'b1, 32'h0000_0000);
        for (int i = 0; i <= 13; i++) begin
            if (i > 0) step();
            applyStimulus(i == 0, I_FENCEI, 32'hFFFF_FFFC, 32'd0, 1'b0, 4'd0);
            icache_inv_ack = (i == 11 || i == 12);
            checkOutput($sformatf("timeout_req_%0d", i), {31'd0, icache_inv_req}, {31'd0, i >= 3 && i <= 10});
        end
        checkOutput("timeout_late_ack_stall", {31'd0, fence_stall}, 32'd0);
        icache_inv_ack = 1'b0;

        $display("[TB] FLUSH_ALL during TLBFL");
        step();
        for (int i = 0; i <= 6; i++) begin
            if (i > 0) step();
            applyStimulus(i == 0, I_SF_X5, 32'h0000_3000, 32'h0000_4000, 1'b0, (i == 4) ? FLUSH_ALL : 4'd0);
            checkOutput($sformatf("flush_req_%0d", i), {31'd0, tlb_flush_req}, {31'd0, i >= 3 && i <= 4});
            checkOutput($sformatf("flush_stall_%0d", i), {31'd0, fence_stall}, {31'd0, i <= 4});
        end
        runFence(32'h0000_3100);

        $display("[TB] flush coincident with detect in IDLE");
        step();
        applyStimulus(1'b1, I_FENCE, 32'h0000_3200, 32'd0, 1'b0, FLUSH_EARLY);
        checkOutput("idle_flush_stall", {31'd0, fence_stall}, 32'd0);
        step();
        applyStimulus(1'b0, I_FENCE, 32'h0000_3200, 32'd0, 1'b0, 4'd0);
        checkOutput("idle_flush_no_capture", {31'd0, fence_stall}, 32'd0);

        $display("[TB] fence held on ID across DONE");
        step();
        c = cyc;
        expectDone(c + 3, 1'b0, 1'b0, 32'd0);
        expectDone(c + 7, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) step();
            applyStimulus(i <= 4, I_FENCE, 32'h0000_4000, 32'd0, 1'b0, 4'd0);
            checkOutput($sformatf("held_stall_%0d", i), {31'd0, fence_stall}, {31'd0, i != 3 && i <= 6});
        end

        $display("[TB] reset mid-DRAIN");
        step();
        applyStimulus(1'b1, I_FENCEI, 32'h0000_5000, 32'h55AA_55AA, 1'b0, 4'd0);
        step();
        applyStimulus(1'b0, I_FENCEI, 32'h0000_5000, 32'd0, 1'b0, 4'd0);
        checkOutput("predrain_stall", {31'd0, fence_stall}, 32'd1);
        checkOutput("predrain_vaddr", tlb_flush_vaddr, 32'h55AA_55AA);
        step();
        rst = 1'b1;
        applyStimulus(1'b1, I_FENCEI, 32'h0000_5000, 32'd0, 1'b0, 4'd0);
        checkOutput("rst_stall", {31'd0, fence_stall}, 32'd0);
        checkOutput("rst_pulses", {29'd0, fence_done, fence_error, refetch_valid}, 32'd0);
        checkOutput("rst_reqs", {29'd0, icache_inv_req, tlb_flush_req, tlb_flush_all}, 32'd0);
        checkOutput("rst_vaddr", tlb_flush_vaddr, 32'd0);
        checkOutput("rst_refetch_pc", refetch_pc, 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            applyStimulus(1'b1, I_ADD, 32'h0000_6000, 32'd0, 1'b0, 4'd0);
            checkOutput($sformatf("add_stall_%0d", i), {31'd0, fence_stall}, 32'd0);
        end

        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0);
        repeat (5) step();
        checkOutput("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
